// File: rtl/pattern_detector.sv
// pattern_detector: mid-bit sampler and lock FSM for the repeating 12-bit serial test frame.
// Define GLITCH_FILTER_EN to add a 3-clock stability filter between the synchronizer and edge detect.
module pattern_detector #(
  parameter int                 BIT_CLKS = 25000000,
  parameter int                 PAT_LEN  = 12,
  parameter logic [PAT_LEN-1:0] PATTERN  = 12'b001110110011
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSIG,
  output logic       oMATCH,
  output logic       oLOCK,
  output logic       oERR,
  output logic [7:0] oFRAMES
);
  localparam int PW = $clog2(BIT_CLKS);
  localparam int FW = $clog2(PAT_LEN + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t             r_state;
  logic [1:0]         r_sync;
  logic               r_prev;
  logic [PW-1:0]      r_phase;
  logic [PAT_LEN-1:0] r_win;
  logic [FW-1:0]      r_fill;
  logic [FW-1:0]      r_bitpos;
  logic               w_sig;
  logic               w_edge;
  logic               w_strobe;
  logic               w_hit;
  logic               w_frame_end;
  logic [PAT_LEN-1:0] w_win_nxt;
  logic [FW-1:0]      w_fill_nxt;

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) r_sync <= '0;
    else         r_sync <= {r_sync[0], iSIG};

`ifdef GLITCH_FILTER_EN
  logic       r_filt;
  logic [1:0] r_stab;
  // r_stab counts consecutive clocks that sSIG disagrees with the filtered level
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      r_filt <= 1'b0;
      r_stab <= '0;
    end else if (r_sync[1] == r_filt) begin
      r_stab <= '0;
    end else if (r_stab == 2'd2) begin
      r_filt <= r_sync[1];
      r_stab <= '0;
    end else begin
      r_stab <= r_stab + 2'd1;
    end
  assign w_sig = r_filt;
`else
  assign w_sig = r_sync[1];
`endif

  assign w_edge      = w_sig ^ r_prev;
  assign w_strobe    = r_phase == PW'(BIT_CLKS / 2 - 1);
  assign w_win_nxt   = {r_win[PAT_LEN-2:0], w_sig};
  assign w_fill_nxt  = (r_fill == FW'(PAT_LEN)) ? r_fill : r_fill + FW'(1);
  assign w_hit       = (w_fill_nxt == FW'(PAT_LEN)) && (w_win_nxt == PATTERN);
  assign w_frame_end = r_bitpos == FW'(PAT_LEN - 1);

  // an edge re-centres the sampling point, taking priority over the wrap
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      r_prev  <= 1'b0;
      r_phase <= '0;
    end else begin
      r_prev  <= w_sig;
      r_phase <= (w_edge || r_phase == PW'(BIT_CLKS - 1)) ? '0 : r_phase + PW'(1);
    end

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      r_state  <= SEARCH;
      r_win    <= '0;
      r_fill   <= '0;
      r_bitpos <= '0;
      oMATCH   <= 1'b0;
      oLOCK    <= 1'b0;
      oERR     <= 1'b0;
      oFRAMES  <= '0;
    end else begin
      oMATCH <= 1'b0;
      oERR   <= 1'b0;
      if (w_strobe) begin
        r_win  <= w_win_nxt;
        r_fill <= w_fill_nxt;
        if (r_state == SEARCH) begin
          if (w_hit) begin
            oMATCH   <= 1'b1;
            oLOCK    <= 1'b1;
            oFRAMES  <= oFRAMES + 8'd1;
            r_bitpos <= '0;
            r_state  <= LOCKED;
          end
        end else if (w_frame_end) begin
          r_bitpos <= '0;
          if (w_win_nxt == PATTERN) begin
            oMATCH  <= 1'b1;
            oFRAMES <= oFRAMES + 8'd1;
          end else begin
            oERR    <= 1'b1;
            oLOCK   <= 1'b0;
            r_state <= SEARCH;
          end
        end else begin
          r_bitpos <= r_bitpos + FW'(1);
        end
      end
    end
endmodule
